wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: four execution units share two regfile write ports.
// Round-robin grant selection, one-cycle registered writeback outputs.
module wb_arbiter #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [3:0]                         req_valid,
  output logic [3:0]                         req_ready,
  input  logic [3:0][PHYS_REG_BITS-1:0]      req_prd,
  input  logic [3:0][4:0]                    req_ard,
  input  logic [3:0][31:0]                   req_data,
  input  logic [3:0][ROB_IDX_BITS-1:0]       req_rob,
  output logic [1:0]                         wb_valid,
  output logic [1:0]                         wb_we,
  output logic [1:0][PHYS_REG_BITS-1:0]      wb_prd,
  output logic [1:0][31:0]                   wb_data,
  output logic [1:0][ROB_IDX_BITS-1:0]       wb_rob
);

  localparam int NUM_PORTS = 2;

  logic [1:0]                          rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]                gnt_vld;
  logic [NUM_PORTS-1:0][1:0]           gnt_idx;

  logic [NUM_PORTS-1:0]                wb_valid_q, wb_we_q;
  logic [NUM_PORTS-1:0][PHYS_REG_BITS-1:0] wb_prd_q;
  logic [NUM_PORTS-1:0][31:0]          wb_data_q;
  logic [NUM_PORTS-1:0][ROB_IDX_BITS-1:0]  wb_rob_q;

  // Scan from rr_ptr with wrap; first hit takes port 0, second takes port 1.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    gnt_vld   = '0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (req_valid[idx] && !flush && !rst) begin
        if (!gnt_vld[0]) begin
          gnt_vld[0]     = 1'b1;
          gnt_idx[0]     = idx;
          req_ready[idx] = 1'b1;
        end else if (!gnt_vld[1]) begin
          gnt_vld[1]     = 1'b1;
          gnt_idx[1]     = idx;
          req_ready[idx] = 1'b1;
        end
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (flush)           rr_ptr_d = 2'd0;
    else if (gnt_vld[1]) rr_ptr_d = gnt_idx[1] + 2'd1;
    else if (gnt_vld[0]) rr_ptr_d = gnt_idx[0] + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= '0;
      wb_we_q    <= '0;
      wb_prd_q   <= '0;
      wb_data_q  <= '0;
      wb_rob_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wb_valid_q[p] <= gnt_vld[p];
        // p0 never receives a regfile write; ard 0 results read as zero
        wb_we_q[p]    <= gnt_vld[p] && (req_prd[gnt_idx[p]] != '0);
        if (gnt_vld[p]) begin
          wb_prd_q[p]  <= req_prd[gnt_idx[p]];
          wb_rob_q[p]  <= req_rob[gnt_idx[p]];
          wb_data_q[p] <= (req_ard[gnt_idx[p]] == 5'd0) ? 32'd0 : req_data[gnt_idx[p]];
        end
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_prd   = wb_prd_q;
  assign wb_data  = wb_data_q;
  assign wb_rob   = wb_rob_q;

endmodule
